// File: rtl/nodf_mon_pkg.sv
// Shared definitions for the non-dataflow module status monitor.
// Contents:
//   DEF_CNT_W / DEF_LAT_W : default counter and latency widths
//   mon_state_t           : monitor state encoding (IDLE/BUSY/DONE_WAIT)
//   sat_inc               : saturating increment for widths up to 64 bits
package nodf_mon_pkg;

  localparam int DEF_CNT_W = 32;
  localparam int DEF_LAT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BUSY      = 2'd1,
    ST_DONE_WAIT = 2'd2
  } mon_state_t;

  // Adds one to a value that lives in the low 'width' bits, sticking at the
  // all-ones value of that width instead of wrapping. Callers cast the result
  // back down to their own width.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
    logic [63:0] limit;
    limit = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    sat_inc = (value >= limit) ? limit : value + 64'd1;
  endfunction

endpackage

// File: rtl/nodf_module_status_monitor_if.sv
// Block-level ap_* handshake of one monitored HLS module.
// Signals:
//   ap_start    : start request
//   ap_ready    : ready-for-next-input
//   ap_done     : completion
//   ap_continue : downstream accepts done
// Modports:
//   master : side that drives the handshake (the monitored module or a bench)
//   slave  : passive observer (the status monitor)
interface nodf_module_status_monitor_if;

  logic ap_start;
  logic ap_ready;
  logic ap_done;
  logic ap_continue;

  modport master (
    output ap_start,
    output ap_ready,
    output ap_done,
    output ap_continue
  );

  modport slave (
    input ap_start,
    input ap_ready,
    input ap_done,
    input ap_continue
  );

endinterface

// File: rtl/nodf_sat_counter.sv
// Saturating up-counter used for every statistic and for the running
// latency counter of the status monitor.
// Ports:
//   clock    : rising-edge clock
//   reset    : asynchronous, active-high; clears count to 0
//   en       : add one (saturating at all-ones)
//   load_one : load the value 1 (takes priority over en)
//   freeze   : hold the current value regardless of en/load_one
//   count    : current counter value
module nodf_sat_counter
  import nodf_mon_pkg::*;
#(
  parameter int WIDTH = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             load_one,
  input  logic             freeze,
  output logic [WIDTH-1:0] count
);

  // Freeze wins over everything so statistics lock once the run is over;
  // load_one restarts a latency measurement, en advances without wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!freeze) begin
      if (load_one) begin
        count <= WIDTH'(1);
      end else if (en) begin
        count <= WIDTH'(sat_inc(64'(count), WIDTH));
      end
    end
  end

endmodule

// File: rtl/nodf_module_status_monitor.sv
// Passive status monitor for one non-dataflow HLS module using the
// ap_start/ap_ready/ap_done/ap_continue block-level handshake.
// Ports:
//   clock        : rising-edge clock
//   reset        : asynchronous, active-high; clears all state
//   hs           : observed handshake (slave modport)
//   finish       : end-of-run flag; locks all statistics from the next edge
//   state        : 0=IDLE, 1=BUSY, 2=DONE_WAIT
//   start_cnt    : accepted transactions
//   ready_cnt    : cycles with ap_ready=1
//   done_cnt     : completed transactions
//   busy_cycles  : cycles from each start cycle through its done cycle
//   stall_cycles : cycles spent in DONE_WAIT
//   last_lat     : latency of the most recent completed transaction
//   max_lat      : largest latency seen
//   min_lat      : smallest latency seen (all-ones until the first completion)
//   frozen       : sticky, finish has been seen
module nodf_module_status_monitor
  import nodf_mon_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int LAT_W = DEF_LAT_W
) (
  input  logic                         clock,
  input  logic                         reset,
  nodf_module_status_monitor_if.slave  hs,
  input  logic                         finish,
  output logic [1:0]                   state,
  output logic [CNT_W-1:0]             start_cnt,
  output logic [CNT_W-1:0]             ready_cnt,
  output logic [CNT_W-1:0]             done_cnt,
  output logic [CNT_W-1:0]             busy_cycles,
  output logic [CNT_W-1:0]             stall_cycles,
  output logic [LAT_W-1:0]             last_lat,
  output logic [LAT_W-1:0]             max_lat,
  output logic [LAT_W-1:0]             min_lat,
  output logic                         frozen
);

  mon_state_t       state_q;
  logic             in_idle;
  logic             in_busy;
  logic             in_wait;
  logic             complete_busy;
  logic             enter_wait;
  logic             complete_now;
  logic             start_accept;
  logic             busy_tick;
  logic [LAT_W-1:0] lat_cnt;
  logic [LAT_W-1:0] lat_capture;
  logic [LAT_W-1:0] done_lat;
  logic [LAT_W-1:0] commit_lat;

  // Event decode for the current cycle. A start is accepted from IDLE, or in
  // the same cycle a transaction completes, which gives back-to-back starts
  // with no idle cycle. The start cycle itself counts as busy, so busy cycles
  // per transaction equal its latency (shared overlap cycles count once).
  assign in_idle       = (state_q == ST_IDLE);
  assign in_busy       = (state_q == ST_BUSY);
  assign in_wait       = (state_q == ST_DONE_WAIT);
  assign complete_busy = in_busy & hs.ap_done & hs.ap_continue;
  assign enter_wait    = in_busy & hs.ap_done & ~hs.ap_continue;
  assign complete_now  = complete_busy | (in_wait & hs.ap_continue);
  assign start_accept  = hs.ap_start & (in_idle | complete_now);
  assign busy_tick     = in_busy | start_accept;
  assign state         = state_q;

  // The latency counter holds (cycles since start) - 1 during the done cycle,
  // so the inclusive start-to-done latency is its saturating successor.
  assign done_lat   = LAT_W'(sat_inc(64'(lat_cnt), LAT_W));
  assign commit_lat = complete_busy ? done_lat : lat_capture;

  // Running latency of the current transaction: restarts at 1 on every
  // accepted start and advances on each BUSY cycle.
  nodf_sat_counter #(.WIDTH(LAT_W)) u_lat_cnt (
    .clock(clock), .reset(reset), .en(in_busy), .load_one(start_accept),
    .freeze(frozen), .count(lat_cnt)
  );

  // Event and residency statistics, all saturating and frozen together.
  nodf_sat_counter #(.WIDTH(CNT_W)) u_start_cnt (
    .clock(clock), .reset(reset), .en(start_accept), .load_one(1'b0),
    .freeze(frozen), .count(start_cnt)
  );

  nodf_sat_counter #(.WIDTH(CNT_W)) u_ready_cnt (
    .clock(clock), .reset(reset), .en(hs.ap_ready), .load_one(1'b0),
    .freeze(frozen), .count(ready_cnt)
  );

  nodf_sat_counter #(.WIDTH(CNT_W)) u_done_cnt (
    .clock(clock), .reset(reset), .en(complete_now), .load_one(1'b0),
    .freeze(frozen), .count(done_cnt)
  );

  nodf_sat_counter #(.WIDTH(CNT_W)) u_busy_cycles (
    .clock(clock), .reset(reset), .en(busy_tick), .load_one(1'b0),
    .freeze(frozen), .count(busy_cycles)
  );

  nodf_sat_counter #(.WIDTH(CNT_W)) u_stall_cycles (
    .clock(clock), .reset(reset), .en(in_wait), .load_one(1'b0),
    .freeze(frozen), .count(stall_cycles)
  );

  // Handshake FSM plus latency bookkeeping. The latency is captured when
  // done is first seen without continue, so DONE_WAIT stall time is not
  // charged to the transaction; it is only published once continue arrives.
  // Events on the edge that samples finish still land; frozen gates the
  // following edges.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      frozen      <= 1'b0;
      lat_capture <= '0;
      last_lat    <= '0;
      max_lat     <= '0;
      min_lat     <= '1;
    end else begin
      if (finish) begin
        frozen <= 1'b1;
      end
      if (!frozen) begin
        case (state_q)
          ST_IDLE: begin
            if (hs.ap_start) begin
              state_q <= ST_BUSY;
            end
          end
          ST_BUSY: begin
            if (hs.ap_done) begin
              if (hs.ap_continue) begin
                state_q <= hs.ap_start ? ST_BUSY : ST_IDLE;
              end else begin
                state_q <= ST_DONE_WAIT;
              end
            end
          end
          ST_DONE_WAIT: begin
            if (hs.ap_continue) begin
              state_q <= hs.ap_start ? ST_BUSY : ST_IDLE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
        if (enter_wait) begin
          lat_capture <= done_lat;
        end
        if (complete_now) begin
          last_lat <= commit_lat;
          if (commit_lat > max_lat) begin
            max_lat <= commit_lat;
          end
          if (commit_lat < min_lat) begin
            min_lat <= commit_lat;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_nodf_module_status_monitor.sv
// Bench for nodf_module_status_monitor. A planned timeline of transactions
// (start cycle, done cycle, continue cycle) is built up front; expected
// statistics come from interval membership and running sums over that plan.
// Two monitors watch the same handshake: default 32-bit widths, and 4-bit
// widths so that saturation shows up within a short run.
module tb_nodf_module_status_monitor;

  localparam int MAXC = 4096;
  localparam int NTX  = 50;
  localparam logic [63:0] SMALL_MAX = 64'd15;
  localparam logic [63:0] BIG_MAX   = 64'hFFFF_FFFF;

  typedef struct {
    logic [63:0] state;
    logic [63:0] start_n;
    logic [63:0] ready_n;
    logic [63:0] done_n;
    logic [63:0] busy_n;
    logic [63:0] stall_n;
    logic [63:0] last_l;
    logic [63:0] max_l;
    logic [63:0] min_l;
    logic [63:0] frozen_f;
    bit          any_done;
  } snap_t;

  logic clock = 1'b0;
  logic reset;
  logic finish;

  logic [1:0]  b_state;
  logic [31:0] b_start_cnt, b_ready_cnt, b_done_cnt, b_busy_cycles, b_stall_cycles;
  logic [31:0] b_last_lat, b_max_lat, b_min_lat;
  logic        b_frozen;

  logic [1:0]  s_state;
  logic [3:0]  s_start_cnt, s_ready_cnt, s_done_cnt, s_busy_cycles, s_stall_cycles;
  logic [3:0]  s_last_lat, s_max_lat, s_min_lat;
  logic        s_frozen;

  bit    st_a    [MAXC];
  bit    rd_a    [MAXC];
  bit    dn_a    [MAXC];
  bit    ct_a    [MAXC];
  bit    busy_f  [MAXC];
  bit    stall_f [MAXC];
  int    st_at   [MAXC];
  int    done_l  [MAXC];
  snap_t exp_snap[MAXC];
  snap_t sb_q[$];

  int n_cycles;
  int finish_cycle;
  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  nodf_module_status_monitor_if bus ();

  nodf_module_status_monitor dut_big (
    .clock(clock), .reset(reset), .hs(bus), .finish(finish),
    .state(b_state), .start_cnt(b_start_cnt), .ready_cnt(b_ready_cnt),
    .done_cnt(b_done_cnt), .busy_cycles(b_busy_cycles), .stall_cycles(b_stall_cycles),
    .last_lat(b_last_lat), .max_lat(b_max_lat), .min_lat(b_min_lat), .frozen(b_frozen)
  );

  nodf_module_status_monitor #(.CNT_W(4), .LAT_W(4)) dut_small (
    .clock(clock), .reset(reset), .hs(bus), .finish(finish),
    .state(s_state), .start_cnt(s_start_cnt), .ready_cnt(s_ready_cnt),
    .done_cnt(s_done_cnt), .busy_cycles(s_busy_cycles), .stall_cycles(s_stall_cycles),
    .last_lat(s_last_lat), .max_lat(s_max_lat), .min_lat(s_min_lat), .frozen(s_frozen)
  );

  function automatic logic [63:0] sat4(input logic [63:0] v);
    return (v > SMALL_MAX) ? SMALL_MAX : v;
  endfunction

  task automatic checkOutput(input string name, input int cyc,
                             input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  task automatic compareSnap(input int cyc, input snap_t e);
    checkOutput("big.state",        cyc, 64'(b_state),        e.state);
    checkOutput("big.start_cnt",    cyc, 64'(b_start_cnt),    e.start_n);
    checkOutput("big.ready_cnt",    cyc, 64'(b_ready_cnt),    e.ready_n);
    checkOutput("big.done_cnt",     cyc, 64'(b_done_cnt),     e.done_n);
    checkOutput("big.busy_cycles",  cyc, 64'(b_busy_cycles),  e.busy_n);
    checkOutput("big.stall_cycles", cyc, 64'(b_stall_cycles), e.stall_n);
    checkOutput("big.last_lat",     cyc, 64'(b_last_lat),     e.last_l);
    checkOutput("big.max_lat",      cyc, 64'(b_max_lat),      e.max_l);
    checkOutput("big.min_lat",      cyc, 64'(b_min_lat),      e.any_done ? e.min_l : BIG_MAX);
    checkOutput("big.frozen",       cyc, 64'(b_frozen),       e.frozen_f);
    checkOutput("small.state",        cyc, 64'(s_state),        e.state);
    checkOutput("small.start_cnt",    cyc, 64'(s_start_cnt),    sat4(e.start_n));
    checkOutput("small.ready_cnt",    cyc, 64'(s_ready_cnt),    sat4(e.ready_n));
    checkOutput("small.done_cnt",     cyc, 64'(s_done_cnt),     sat4(e.done_n));
    checkOutput("small.busy_cycles",  cyc, 64'(s_busy_cycles),  sat4(e.busy_n));
    checkOutput("small.stall_cycles", cyc, 64'(s_stall_cycles), sat4(e.stall_n));
    checkOutput("small.last_lat",     cyc, 64'(s_last_lat),     sat4(e.last_l));
    checkOutput("small.max_lat",      cyc, 64'(s_max_lat),      sat4(e.max_l));
    checkOutput("small.min_lat",      cyc, 64'(s_min_lat),      e.any_done ? sat4(e.min_l) : SMALL_MAX);
    checkOutput("small.frozen",       cyc, 64'(s_frozen),       e.frozen_f);
  endtask

  // Plans the whole run: 20 quiet cycles, a few fixed transactions covering
  // plain completion, a 3-cycle continue stall, a back-to-back pair, a long
  // transaction and a ready-only stretch, then random transactions. The last
  // one is still in flight when finish rises.
  task automatic buildTimeline();
    int prev_c, s, d, c, gap, lat, w;
    bit b2b;
    snap_t cur;
    for (int t = 0; t < MAXC; t++) begin
      st_a[t] = 0; rd_a[t] = 0; dn_a[t] = 0; ct_a[t] = 0;
      busy_f[t] = 0; stall_f[t] = 0; st_at[t] = 0; done_l[t] = 0;
    end
    for (int t = 20; t < MAXC; t++) begin
      rd_a[t] = 1'($urandom_range(0, 1));
      dn_a[t] = ($urandom_range(0, 3) == 0);
      ct_a[t] = 1'($urandom_range(0, 1));
    end
    prev_c = 19;
    s = 0;
    for (int i = 0; i < NTX; i++) begin
      b2b = 0;
      case (i)
        0: begin gap = 0; lat = 6;  w = 0; end
        1: begin gap = 2; lat = 4;  w = 3; end
        2: begin gap = 1; lat = 6;  w = 0; end
        3: begin b2b = 1; gap = 0; lat = 3; w = 0; end
        4: begin gap = 0; lat = 20; w = 0; end
        5: begin gap = 8; lat = 5;  w = 2; end
        NTX - 1: begin gap = 1; lat = 8; w = 0; end
        default: begin
          b2b = ($urandom_range(0, 3) == 0);
          gap = $urandom_range(0, 3);
          lat = $urandom_range(2, 8);
          w   = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
        end
      endcase
      s = b2b ? prev_c : prev_c + 1 + gap;
      d = s + lat - 1;
      c = d + w;
      if (i == 5) begin
        for (int t = prev_c + 1; t < s; t++) begin
          dn_a[t] = 0;
          ct_a[t] = 0;
        end
      end
      st_a[s] = 1;
      for (int t = s + 1; t < d; t++) dn_a[t] = 0;
      for (int t = d; t <= c; t++) dn_a[t] = 1;
      ct_a[d] = (w == 0);
      for (int t = d + 1; t < c; t++) ct_a[t] = 0;
      if (w > 0) ct_a[c] = 1;
      for (int t = s; t <= d; t++) busy_f[t] = 1;
      for (int t = d + 1; t <= c; t++) stall_f[t] = 1;
      for (int t = s + 1; t <= d; t++) st_at[t] = 1;
      for (int t = d + 1; t <= c; t++) st_at[t] = 2;
      done_l[c] = lat;
      prev_c = c;
    end
    finish_cycle = s + 3;
    n_cycles = finish_cycle + 30;

    cur = '{default: '0};
    for (int t = 0; t < n_cycles; t++) begin
      if (t <= finish_cycle) begin
        cur.start_n += 64'(st_a[t]);
        cur.ready_n += 64'(rd_a[t]);
        cur.busy_n  += 64'(busy_f[t]);
        cur.stall_n += 64'(stall_f[t]);
        if (done_l[t] != 0) begin
          cur.done_n += 64'd1;
          cur.last_l  = 64'(done_l[t]);
          if (!cur.any_done || 64'(done_l[t]) > cur.max_l) cur.max_l = 64'(done_l[t]);
          if (!cur.any_done || 64'(done_l[t]) < cur.min_l) cur.min_l = 64'(done_l[t]);
          cur.any_done = 1;
        end
        cur.state = 64'(st_at[t + 1]);
      end
      cur.frozen_f = (t >= finish_cycle) ? 64'd1 : 64'd0;
      exp_snap[t] = cur;
    end
  endtask

  task automatic applyStimulus(input int k);
    bus.ap_start    = st_a[k];
    bus.ap_ready    = rd_a[k];
    bus.ap_done     = dn_a[k];
    bus.ap_continue = ct_a[k];
    finish          = (k >= finish_cycle);
    sb_q.push_back(exp_snap[k]);
  endtask

  // Monitor: one expectation per clock edge after reset release.
  initial begin
    snap_t e;
    int mon_cycle;
    mon_cycle = 0;
    forever begin
      @(posedge clock);
      #1;
      if (!reset && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        compareSnap(mon_cycle, e);
        mon_cycle++;
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    snap_t zero;
    zero = '{default: '0};
    reset = 1'b1;
    finish = 1'b0;
    bus.ap_start = 1'b0;
    bus.ap_ready = 1'b0;
    bus.ap_done = 1'b0;
    bus.ap_continue = 1'b0;
    buildTimeline();
    $display("[TB] planned %0d cycles, finish at cycle %0d", n_cycles, finish_cycle);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < n_cycles; k++) begin
      applyStimulus(k);
      @(negedge clock);
    end

    bus.ap_start = 1'b0;
    bus.ap_ready = 1'b0;
    bus.ap_done = 1'b0;
    bus.ap_continue = 1'b0;
    finish = 1'b0;
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    compareSnap(-1, zero);

    @(negedge clock);
    reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    compareSnap(-2, zero);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
